// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types and constants for the ASCON output serializer.
//   state_t : serializer FSM states (IDLE, LEAD, SHIFT, DONE)
//   TAG_W   : tag width in bits
//   clog2() : ceiling log2, used to size the shift-cycle counter
package ascon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int TAG_W = 128;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/ascon_out_serializer_if.sv
// ascon_out_serializer_if: parallel result bus from the ASCON core to the
// output serializer.
//   core_donexSI    : one-cycle completion pulse
//   core_decxSI     : decrypt flag, valid with core_donexSI
//   core_dataxDI    : Y-bit plaintext/ciphertext, bit 0 transmitted first
//   core_tagxDI     : 128-bit tag computed by the core
//   expected_tagxDI : received tag, compared only with ASCON_TAG_CHECK_EN
// Modports: master = ASCON core side, slave = serializer side.
interface ascon_out_serializer_if
  import ascon_pkg::*;
#(
  parameter int Y = 104
) ();

  logic             core_donexSI;
  logic             core_decxSI;
  logic [Y-1:0]     core_dataxDI;
  logic [TAG_W-1:0] core_tagxDI;
  logic [TAG_W-1:0] expected_tagxDI;

  modport master (
    output core_donexSI, core_decxSI, core_dataxDI, core_tagxDI, expected_tagxDI
  );

  modport slave (
    input core_donexSI, core_decxSI, core_dataxDI, core_tagxDI, expected_tagxDI
  );

endinterface

// File: rtl/ascon_piso.sv
// ascon_piso: parallel-load, LSB-first shift register. Zeros shift in from
// the top, so bits beyond W read back as 0 once the word is exhausted.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : shift right by one
//   din      : parallel load value
//   lsb      : current bit 0 of the register
module ascon_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb
);

  logic [W-1:0] sr;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; the shadow word is also reset so a transfer never
  // leaks bits from a result captured before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr >> 1;
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/ascon_out_serializer.sv
// ascon_out_serializer: captures the ASCON core result on core_donexSI and
// shifts data and tag out bit-serially, LSB first, on two GPIO lines.
// Optional feature macro: ASCON_TAG_CHECK_EN (decrypt tag comparison and
// plaintext suppression on mismatch).
//   clk, rst        : clock, synchronous active-high reset
//   core            : result bus (slave modport)
//   output_dataxSO  : serial data line
//   tagxSO          : serial tag line
//   ascon_readyxSO  : result captured, being or already delivered
//   busyxSO         : in LEAD or SHIFT
//   overrunxSO      : sticky, completion pulse seen while busy
//   tag_okxSO       : decryption tag matched
// All outputs are registered.
module ascon_out_serializer
  import ascon_pkg::*;
#(
  parameter int Y    = 104,
  parameter int LEAD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ascon_out_serializer_if.slave  core,
  output logic                   output_dataxSO,
  output logic                   tagxSO,
  output logic                   ascon_readyxSO,
  output logic                   busyxSO,
  output logic                   overrunxSO,
  output logic                   tag_okxSO
);

  localparam int               N         = (Y > TAG_W) ? Y : TAG_W;
  localparam int               CNT_W     = clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [3:0]       LEAD_LAST = (LEAD == 0) ? 4'd0 : 4'(LEAD - 1);
  // With no lead-in, bit 0 leaves on the capture edge itself, so the shift
  // registers are loaded already advanced by one position.
  localparam bit               DIRECT    = (LEAD == 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lead_cnt;
  logic             suppress;

  logic             capture;
  logic             piso_shift;
  logic             data_lsb;
  logic             tag_lsb;
  logic             cap_tag_ok;
  logic             cap_suppress;
  logic [Y-1:0]     data_load;
  logic [TAG_W-1:0] tag_load;

  assign capture    = core.core_donexSI && (state == S_IDLE || state == S_DONE);
  assign piso_shift = (state == S_LEAD  && lead_cnt == LEAD_LAST) ||
                      (state == S_SHIFT && cnt != CNT_LAST);
  assign data_load  = DIRECT ? (core.core_dataxDI >> 1) : core.core_dataxDI;
  assign tag_load   = DIRECT ? (core.core_tagxDI  >> 1) : core.core_tagxDI;

  // NOTE: every signal assigned here gets a default first so no latch is
  // inferred when the feature macro removes the assignments below.
  always_comb begin
    cap_tag_ok   = 1'b0;
    cap_suppress = 1'b0;
`ifdef ASCON_TAG_CHECK_EN
    cap_tag_ok   = core.core_decxSI && (core.core_tagxDI == core.expected_tagxDI);
    cap_suppress = core.core_decxSI && (core.core_tagxDI != core.expected_tagxDI);
`endif
  end

`ifndef ASCON_TAG_CHECK_EN
  logic unused_tag_check_inputs;
  assign unused_tag_check_inputs = ^{core.core_decxSI, core.expected_tagxDI};
`endif

  ascon_piso #(.W(Y)) u_data_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (capture),
    .shift (piso_shift),
    .din   (data_load),
    .lsb   (data_lsb)
  );

  ascon_piso #(.W(TAG_W)) u_tag_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (capture),
    .shift (piso_shift),
    .din   (tag_load),
    .lsb   (tag_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lead_cnt       <= '0;
      suppress       <= 1'b0;
      output_dataxSO <= 1'b0;
      tagxSO         <= 1'b0;
      ascon_readyxSO <= 1'b0;
      busyxSO        <= 1'b0;
      overrunxSO     <= 1'b0;
      tag_okxSO      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          output_dataxSO <= 1'b0;
          tagxSO         <= 1'b0;
          if (core.core_donexSI) begin
            ascon_readyxSO <= 1'b1;
            busyxSO        <= 1'b1;
            tag_okxSO      <= cap_tag_ok;
            suppress       <= cap_suppress;
            cnt            <= '0;
            lead_cnt       <= '0;
            if (DIRECT) begin
              state          <= S_SHIFT;
              output_dataxSO <= core.core_dataxDI[0] & ~cap_suppress;
              tagxSO         <= core.core_tagxDI[0];
            end else begin
              state <= S_LEAD;
            end
          end
        end

        S_LEAD: begin
          if (core.core_donexSI) overrunxSO <= 1'b1;
          if (lead_cnt == LEAD_LAST) begin
            state          <= S_SHIFT;
            cnt            <= '0;
            output_dataxSO <= data_lsb & ~suppress;
            tagxSO         <= tag_lsb;
          end else begin
            lead_cnt <= lead_cnt + 4'd1;
          end
        end

        S_SHIFT: begin
          if (core.core_donexSI) overrunxSO <= 1'b1;
          if (cnt == CNT_LAST) begin
            state          <= S_DONE;
            busyxSO        <= 1'b0;
            output_dataxSO <= 1'b0;
            tagxSO         <= 1'b0;
          end else begin
            cnt            <= cnt + CNT_W'(1);
            output_dataxSO <= data_lsb & ~suppress;
            tagxSO         <= tag_lsb;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_out_serializer.sv
// tb_ascon_out_serializer: drives two serializers (LEAD=4 and LEAD=0) from
// identical stimulus and checks every output every cycle against a
// transaction-level model: each output is derived from the number of cycles
// elapsed since the last accepted completion pulse.
module tb_ascon_out_serializer;
  import ascon_pkg::*;

  localparam int Y     = 104;
  localparam int N     = (Y > TAG_W) ? Y : TAG_W;
  localparam int LEAD0 = 4;
  localparam int LEAD1 = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_out_serializer_if #(.Y(Y)) bus0 ();
  ascon_out_serializer_if #(.Y(Y)) bus1 ();

  logic od [2];
  logic tg [2];
  logic rdy[2];
  logic bsy[2];
  logic ovr[2];
  logic tok[2];

  ascon_out_serializer #(.Y(Y), .LEAD(LEAD0)) dut0 (
    .clk(clk), .rst(rst), .core(bus0),
    .output_dataxSO(od[0]), .tagxSO(tg[0]), .ascon_readyxSO(rdy[0]),
    .busyxSO(bsy[0]), .overrunxSO(ovr[0]), .tag_okxSO(tok[0])
  );

  ascon_out_serializer #(.Y(Y), .LEAD(LEAD1)) dut1 (
    .clk(clk), .rst(rst), .core(bus1),
    .output_dataxSO(od[1]), .tagxSO(tg[1]), .ascon_readyxSO(rdy[1]),
    .busyxSO(bsy[1]), .overrunxSO(ovr[1]), .tag_okxSO(tok[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, one entry per DUT.
  bit               have_cap[2];
  int               t_cap   [2];
  logic [Y-1:0]     m_data  [2];
  logic [TAG_W-1:0] m_tag   [2];
  bit               m_ok    [2];
  bit               m_sup   [2];
  bit               m_ovr   [2];
  logic [Y-1:0]     rec_data[2];
  logic [TAG_W-1:0] rec_tag [2];

  // Stimulus values.
  logic             s_done;
  logic             s_dec;
  logic [Y-1:0]     s_data;
  logic [TAG_W-1:0] s_tag;
  logic [TAG_W-1:0] s_exp;

  function automatic int lead_of(input int d);
    return (d == 0) ? LEAD0 : LEAD1;
  endfunction

  function automatic logic [TAG_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", name, cyc, obs, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [TAG_W-1:0] obs,
                           input logic [TAG_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", name, cyc, obs, exp);
    end
  endtask

  task automatic apply();
    bus0.core_donexSI = s_done;  bus1.core_donexSI = s_done;
    bus0.core_decxSI  = s_dec;   bus1.core_decxSI  = s_dec;
    bus0.core_dataxDI = s_data;  bus1.core_dataxDI = s_data;
    bus0.core_tagxDI  = s_tag;   bus1.core_tagxDI  = s_tag;
    bus0.expected_tagxDI = s_exp;
    bus1.expected_tagxDI = s_exp;
  endtask

  // Model reaction to one rising edge, from the inputs sampled there.
  task automatic model_edge(input int d);
    int  k;
    bit  busy_now;
    if (rst) begin
      have_cap[d] = 1'b0;
      m_ovr[d]    = 1'b0;
      return;
    end
    k        = cyc - t_cap[d];
    busy_now = have_cap[d] && (k >= 1) && (k <= lead_of(d) + N);
    if (s_done) begin
      if (busy_now) begin
        m_ovr[d] = 1'b1;
      end else begin
        have_cap[d] = 1'b1;
        t_cap[d]    = cyc;
        m_data[d]   = s_data;
        m_tag[d]    = s_tag;
        m_ok[d]     = 1'b0;
        m_sup[d]    = 1'b0;
`ifdef ASCON_TAG_CHECK_EN
        m_ok[d]     = s_dec && (s_tag == s_exp);
        m_sup[d]    = s_dec && (s_tag != s_exp);
`endif
        rec_data[d] = '0;
        rec_tag[d]  = '0;
      end
    end
  endtask

  task automatic check_dut(input int d);
    int   k;
    int   i;
    logic e_data, e_tag, e_busy, e_ok;
    e_data = 1'b0;
    e_tag  = 1'b0;
    e_busy = 1'b0;
    e_ok   = 1'b0;
    if (have_cap[d]) begin
      k      = cyc + 1 - t_cap[d];
      e_busy = (k <= lead_of(d) + N);
      e_ok   = m_ok[d];
      i      = k - 1 - lead_of(d);
      if (i >= 0 && i < N) begin
        if (i < TAG_W) begin
          e_tag = m_tag[d][i];
          rec_tag[d][i] = tg[d];
        end
        if (i < Y) begin
          e_data = m_data[d][i] & ~m_sup[d];
          rec_data[d][i] = od[d];
        end
      end
    end
    check($sformatf("dut%0d_data", d),    od[d],  e_data);
    check($sformatf("dut%0d_tag", d),     tg[d],  e_tag);
    check($sformatf("dut%0d_ready", d),   rdy[d], have_cap[d]);
    check($sformatf("dut%0d_busy", d),    bsy[d], e_busy);
    check($sformatf("dut%0d_overrun", d), ovr[d], m_ovr[d]);
    check($sformatf("dut%0d_tag_ok", d),  tok[d], e_ok);
  endtask

  task automatic step();
    apply();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic pulse();
    s_done = 1'b1;
    step();
    s_done = 1'b0;
  endtask

  // Reassembled bits of the last transfer against what the host should read.
  task automatic check_transfer(input string name, input logic [Y-1:0] data,
                                input logic [TAG_W-1:0] tag);
    for (int d = 0; d < 2; d++) begin
      check_vec($sformatf("%s_dut%0d_data", name, d), TAG_W'(rec_data[d]),
                m_sup[d] ? '0 : TAG_W'(data));
      check_vec($sformatf("%s_dut%0d_tag", name, d), rec_tag[d], tag);
    end
  endtask

  logic [Y-1:0]     keep_data;
  logic [TAG_W-1:0] keep_tag;

  initial begin
    for (int d = 0; d < 2; d++) begin
      have_cap[d] = 1'b0; t_cap[d] = 0; m_data[d] = '0; m_tag[d] = '0;
      m_ok[d] = 1'b0; m_sup[d] = 1'b0; m_ovr[d] = 1'b0;
      rec_data[d] = '0; rec_tag[d] = '0;
    end
    s_done = 1'b0; s_dec = 1'b0; s_data = '0; s_tag = '0; s_exp = '0;
    apply();

    // Reset state.
    rst = 1'b1;
    steps(3);
    rst = 1'b0;
    steps(2);

    // Encryption with the reference vectors.
    s_dec  = 1'b0;
    s_data = 104'h6173636f6e2d756e6963617373;
    s_tag  = 128'h0123456789abcdef0011223344556677;
    s_exp  = '0;
    pulse();
    s_data = '0; s_tag = '0;
    steps(LEAD0 + N + 3);
    check_transfer("enc", 104'h6173636f6e2d756e6963617373,
                   128'h0123456789abcdef0011223344556677);

    // Decryption, matching tags.
    s_dec  = 1'b1;
    s_data = 104'h18490112f8d5867a830748390b;
    s_tag  = rand128();
    s_exp  = s_tag;
    keep_tag = s_tag;
    pulse();
    steps(LEAD0 + N + 3);
    check_transfer("dec_ok", 104'h18490112f8d5867a830748390b, keep_tag);

    // Decryption, tag mismatch in bit 0.
    s_data = Y'(rand128());
    s_tag  = rand128();
    s_exp  = s_tag ^ 128'd1;
    keep_data = s_data; keep_tag = s_tag;
    pulse();
    steps(LEAD0 + N + 3);
    check_transfer("dec_bad", keep_data, keep_tag);

    // Second pulse mid-SHIFT, then a third pulse in DONE.
    s_dec  = 1'b0;
    s_data = Y'(rand128()); s_tag = rand128();
    keep_data = s_data; keep_tag = s_tag;
    pulse();
    steps(LEAD0 + 50);
    s_data = Y'(rand128()); s_tag = rand128();
    pulse();
    steps(N);
    check_transfer("overrun_keep", keep_data, keep_tag);
    s_data = Y'(rand128()); s_tag = rand128();
    keep_data = s_data; keep_tag = s_tag;
    pulse();
    steps(LEAD0 + N + 3);
    check_transfer("restart", keep_data, keep_tag);

    // Reset during SHIFT at i=20, then a full fresh transfer.
    s_data = Y'(rand128()); s_tag = rand128();
    pulse();
    steps(LEAD0 + 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(3);

    // Completion held high for three cycles: first captures, rest overrun.
    s_data = Y'(rand128()); s_tag = rand128();
    keep_data = s_data; keep_tag = s_tag;
    s_done = 1'b1;
    step();
    s_data = Y'(rand128()); s_tag = rand128();
    steps(2);
    s_done = 1'b0;
    steps(LEAD0 + N + 3);
    check_transfer("held_done", keep_data, keep_tag);

    // Randomized traffic.
    for (int j = 0; j < 600; j++) begin
      s_done = ($urandom_range(0, 24) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      s_dec  = $urandom_range(0, 1) != 0;
      s_data = Y'(rand128());
      s_tag  = rand128();
      s_exp  = ($urandom_range(0, 1) != 0) ? s_tag
                                           : s_tag ^ (128'd1 << $urandom_range(0, 127));
      step();
    end
    rst = 1'b0; s_done = 1'b0;
    steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
